// File: rtl/write8to32.sv
// write8to32: packs a ready/valid byte stream into little-endian 32-bit words
// and emits one (address, data) write tuple per word at base + ADDR_STRIDE*i.
// After the last tuple is handed off, a DONE tuple (_done=1, _valid=1) is
// presented until the downstream accepts it.
module write8to32 #(
    parameter int BYTES_PER_WORD = 4,
    parameter int ADDR_STRIDE    = 4
) (
    input  logic               _clock,
    input  logic               _reset,
    input  logic signed [31:0] base,
    input  logic signed [31:0] count,
    input  logic               _start,
    input  logic        [7:0]  byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               _ready,
    output logic               _valid,
    output logic               _done,
    output logic signed [31:0] _out0,
    output logic signed [31:0] _out1
);

    localparam int J_W = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                    state_reg, state_next;
    logic signed [31:0]        base_reg;
    logic signed [31:0]        count_reg;
    logic        [31:0]        i_reg;
    logic        [J_W-1:0]     j_reg;
    logic [8*BYTES_PER_WORD-1:0] merged_word;

    // Per-cycle strobes decoded by the FSM.
    logic accept;     // a byte is consumed this edge
    logic last_byte;  // the consumed byte completes a word
    logic retire;     // the pending data tuple is handed off this edge

    // State register.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; _start overrides everything, so it
    // also masks byte_ready and the tuple handshake in the same cycle.
    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        _valid     = 1'b0;
        _done      = 1'b0;
        accept     = 1'b0;
        last_byte  = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            GATHER: begin
                byte_ready = !_start;
                accept     = byte_valid && !_start;
                last_byte  = accept && (j_reg == J_W'(BYTES_PER_WORD - 1));
                if (last_byte) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                _valid = 1'b1;
                retire = _ready && !_start;
                if (retire) begin
                    state_next = ((i_reg + 32'd1) == $unsigned(count_reg)) ? DONE : GATHER;
                end
            end
            DONE: begin
                _valid = 1'b1;
                _done  = 1'b1;
                if (_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (_start) begin
            state_next = (count <= 32'sd0) ? DONE : GATHER;
        end
    end

    // Byte lanes of the word under construction. The merged view substitutes
    // the incoming byte into its lane so the final byte lands in the tuple on
    // the same edge that accepts it.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : gen_lane
        logic [7:0] lane_reg;

        // Lane capture; a new transfer discards any partial word.
        always_ff @(posedge _clock or posedge _reset) begin
            if (_reset) begin
                lane_reg <= '0;
            end else if (_start) begin
                lane_reg <= '0;
            end else if (accept && (j_reg == J_W'(gi))) begin
                lane_reg <= byte_in;
            end
        end

        assign merged_word[8*gi +: 8] = (j_reg == J_W'(gi)) ? byte_in : lane_reg;
    end

    // Transfer parameters, word/byte indices and the output tuple registers.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            base_reg  <= '0;
            count_reg <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            _out0     <= '0;
            _out1     <= '0;
        end else if (_start) begin
            base_reg  <= base;
            count_reg <= count;
            i_reg     <= '0;
            j_reg     <= '0;
        end else begin
            if (accept) begin
                j_reg <= last_byte ? '0 : j_reg + 1'b1;
            end
            if (last_byte) begin
                _out1 <= merged_word;
                _out0 <= base_reg + (32'(ADDR_STRIDE) * i_reg);
            end
            if (retire) begin
                i_reg <= i_reg + 32'd1;
            end
        end
    end

endmodule

// File: doc/write8to32.md
Name: write8to32

Overview:
- Byte-stream-to-word packer and memory-write command generator.
- Consumes a ready/valid stream of 8-bit bytes and packs each group of 4 bytes little-endian into a 32-bit word.
- Emits one (address, word) write tuple per word at base + 4*i, for i = 0..count-1; raises _done after the last word.
- Write-side counterpart of the 32-to-8 read generator; its output feeds the memory write port.

Parameters:
- BYTES_PER_WORD, 4, bytes packed per output word (fixed at 4; other values unsupported).
- ADDR_STRIDE, 4, address increment per emitted word.

Ports:
- _clock  in  1  single clock, all state on rising edge
- _reset  in  1  asynchronous, active-high reset
- base  in  32 signed  first write address; sampled only when _start high
- count  in  32 signed  number of words to write; sampled only when _start high
- _start  in  1  captures base/count and begins a transfer; takes precedence over all other inputs
- byte_in  in  8  input byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  block accepts byte_in this cycle
- _ready  in  1  downstream ready for output tuple
- _valid  out  1  _out0/_out1 (or _done) valid
- _done  out  1  transfer complete; asserted together with _valid
- _out0  out  32 signed  write address
- _out1  out  32 signed  write data word

Behaviour:
- Reset (async, while _reset high):
  - State is IDLE; internal word index i = 0, byte index j = 0, shift word = 0.
  - byte_ready = 0, _valid = 0, _done = 0, _out0 = 0, _out1 = 0.
- States and transitions:
  - IDLE: byte_ready = 0, _valid = 0. Holds until _start.
  - _start edge, from any state:
    - Capture _base = base and _count = count; i = 0, j = 0, word = 0.
    - Clear _valid and _done.
    - If count <= 0, go to DONE; otherwise go to GATHER.
    - Any partial word or pending tuple is discarded, with no output for it.
  - GATHER: byte_ready = 1.
    - On each edge with byte_valid high, word[8*j+7:8*j] = byte_in and j = j + 1.
    - On acceptance of the 4th byte (j == 3): drive _out1 = packed word and _out0 = _base + ADDR_STRIDE*i (32-bit signed, wrap on overflow). Set _valid = 1, j = 0, and go to EMIT.
  - EMIT: byte_ready = 0; _valid, _out0 and _out1 held stable.
    - On an edge with _ready high: _valid = 0, i = i + 1.
    - If i + 1 == _count, go to DONE; otherwise go to GATHER.
  - DONE: _done = 1, _valid = 1, _out0/_out1 unchanged. On an edge with _ready high, clear _done and _valid and go to IDLE.
- Latency and throughput:
  - Tuple _valid is asserted on the edge that accepts the 4th byte.
  - Minimum of 4 GATHER cycles plus 1 EMIT cycle per word.
  - DONE is entered on the edge after the last tuple's handshake.
- Handshake rules:
  - A byte transfers iff byte_valid && byte_ready at the edge.
  - A tuple transfers iff _valid && _ready at the edge.
  - _valid is never deasserted without _ready, except on _start or _reset.
  - _ready held high continuously with _valid low has no effect.
- Boundary conditions:
  - byte_valid with byte_ready low: byte not consumed; the source must hold it.
  - Bytes arriving with gaps: j is preserved across idle cycles.
  - count = 1: exactly one tuple, then DONE.
  - _start asserted simultaneously with _ready in EMIT: _start wins and the tuple is dropped.
  - _reset deasserting mid-cycle: the next edge behaves as IDLE.
  - Address arithmetic is 32-bit two's complement; base = 0x7FFFFFFC with count = 2 gives second address 0x80000000.

Test Plan:
- base=100, count=1; bytes 0x11,0x22,0x33,0x44 back-to-back; _ready=1 -> one tuple (_out0=100, _out1=0x44332211), then one cycle of _done=1/_valid=1, then IDLE.
- base=0, count=3; bytes 0x00..0x0B; _ready=1 -> tuples (0,0x03020100), (4,0x07060504), (8,0x0B0A0908); byte_ready low during each EMIT cycle; then _done.
- count=2; _ready held low for 5 cycles on the first tuple -> _out0/_out1/_valid stable throughout, byte_ready stays 0, no bytes consumed; tuple released on the first _ready edge.
- count=0 and count=-3 -> no bytes accepted, _done=1/_valid=1 on the cycle after _start, cleared by _ready.
- _start again after 2 bytes of word 0 (new base=200, count=1) -> partial bytes discarded; next 4 bytes 0xAA,0xBB,0xCC,0xDD give tuple (200, 0xDDCCBBAA).
- Assert _reset asynchronously mid-EMIT (between edges) -> _valid, _done and byte_ready drop immediately; outputs read 0; no tuple is emitted until the next _start.
